// File: rtl/llc_set_admit_ctrl.sv
// llc_set_admit_ctrl: admits one request per cycle into the LLC pipeline, blocking sets already in flight; LLC_ADMIT_RR_EN selects round-robin over fixed priority
module llc_set_admit_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int TABLE_SIZE   = 5,
  parameter int LLC_SET_BITS = 8,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int PTR_W        = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LLC_SET_BITS-1:0] req_set,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [ID_W-1:0]                 issue_req_id,
  output logic [LLC_SET_BITS-1:0]         issue_set,
  output logic [PTR_W-1:0]                issue_entry,
  input  logic                            retire_valid,
  input  logic [PTR_W-1:0]                retire_entry,
  input  logic                            drain_req,
  output logic                            drain_done,
  output logic                            table_full,
  output logic [PTR_W:0]                  occupancy
);
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
  state_t state, state_nxt;
  logic [TABLE_SIZE-1:0] tbl_valid, ret_sel, alloc_sel;
  logic [LLC_SET_BITS-1:0] tbl_set [TABLE_SIZE];
  logic [NUM_REQ-1:0] elig;
  logic gnt, ret_hit, issue_valid_nxt;
  logic [ID_W-1:0] gnt_id;
  logic [PTR_W-1:0] free_idx;
  logic [LLC_SET_BITS-1:0] gnt_set;
  logic [PTR_W:0] occ_nxt;

  assign table_full      = occupancy == (PTR_W+1)'(TABLE_SIZE);
  assign drain_done      = state == DRAINED;
  assign req_ready       = gnt ? NUM_REQ'(1) << gnt_id : '0;
  assign gnt_set         = req_set[int'(gnt_id)*LLC_SET_BITS +: LLC_SET_BITS];
  assign ret_sel         = TABLE_SIZE'(1) << retire_entry;
  assign ret_hit         = retire_valid && |(tbl_valid & ret_sel);
  assign alloc_sel       = TABLE_SIZE'(gnt) << free_idx;
  assign occ_nxt         = occupancy + (PTR_W+1)'(gnt) - (PTR_W+1)'(ret_hit);
  assign issue_valid_nxt = gnt || (issue_valid && !issue_ready);

  // eligibility uses the pre-edge table, so a set being retired this cycle stays blocked
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && state == RUN && !drain_req && !table_full && (!issue_valid || issue_ready);
      for (int j = 0; j < TABLE_SIZE; j++)
        if (tbl_valid[j] && tbl_set[j] == req_set[i*LLC_SET_BITS +: LLC_SET_BITS]) elig[i] = 1'b0;
    end
  end

`ifdef LLC_ADMIT_RR_EN
  logic [ID_W-1:0] last_id, rr_idx;

  // round-robin: search begins just after the last granted requester
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (!gnt && elig[rr_idx]) begin
        gnt = 1'b1;
        gnt_id = rr_idx;
      end
    end
  end

  // last-grant pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_id <= '0;
    else if (gnt) last_id <= gnt_id;
`else
  // fixed priority: lowest index wins
  always_comb begin
    gnt = |elig;
    gnt_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[k]) gnt_id = ID_W'(k);
  end
`endif

  // lowest free entry of the pre-edge table; a retiring entry is still valid here
  always_comb begin
    free_idx = '0;
    for (int j = TABLE_SIZE - 1; j >= 0; j--)
      if (!tbl_valid[j]) free_idx = PTR_W'(j);
  end

  // drain completes once the table and issue register will both be empty after this edge
  always_comb
    state_nxt = state == RUN ? (drain_req ? DRAIN : RUN)
              : !drain_req ? RUN
              : (occ_nxt == '0 && !issue_valid_nxt) ? DRAINED : state;

  // state, table valid bits and occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      tbl_valid <= '0;
      occupancy <= '0;
    end else begin
      state <= state_nxt;
      tbl_valid <= (tbl_valid & ~(ret_hit ? ret_sel : '0)) | alloc_sel;
      occupancy <= occ_nxt;
    end

  // set tags only matter while their valid bit is set
  always_ff @(posedge clk)
    if (gnt) tbl_set[free_idx] <= gnt_set;

  // issue register holds its payload until the pipeline accepts it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_req_id <= '0;
      issue_set <= '0;
      issue_entry <= '0;
    end else begin
      issue_valid <= issue_valid_nxt;
      if (gnt) begin
        issue_req_id <= gnt_id;
        issue_set <= gnt_set;
        issue_entry <= free_idx;
      end
    end
endmodule

// File: tb/tb_llc_set_admit_ctrl.sv
// tb_llc_set_admit_ctrl: directed vectors, grant-order and drain sequences, and randomized traffic against a table model
module tb_llc_set_admit_ctrl;
  localparam int NR = 4, TS = 5, SB = 8, PW = 3, IW = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*SB-1:0] req_set = '0;
  logic issue_valid, issue_ready = 1'b0;
  logic [IW-1:0] issue_req_id;
  logic [SB-1:0] issue_set;
  logic [PW-1:0] issue_entry, retire_entry = '0;
  logic retire_valid = 1'b0, drain_req = 1'b0, drain_done, table_full;
  logic [PW:0] occupancy;
  int n_vec = 0, n_err = 0;

  llc_set_admit_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_id(issue_req_id),
    .issue_set(issue_set), .issue_entry(issue_entry), .retire_valid(retire_valid),
    .retire_entry(retire_entry), .drain_req(drain_req), .drain_done(drain_done),
    .table_full(table_full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic m_v [TS];
  logic [SB-1:0] m_s [TS];
  int m_st, m_id, m_ient, m_last;
  logic m_iv;
  logic [SB-1:0] m_iset;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int j = 0; j < TS; j++) begin
      m_v[j] = 1'b0;
      m_s[j] = '0;
    end
    m_st = 0; m_id = 0; m_ient = 0; m_last = 0; m_iv = 1'b0; m_iset = '0;
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int j = 0; j < TS; j++) c += int'(m_v[j]);
    return c;
  endfunction

  function automatic logic m_hit(input logic [SB-1:0] s);
    for (int j = 0; j < TS; j++) if (m_v[j] && m_s[j] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] m_ready();
    if (m_st != 0 || drain_req || m_occ() == TS || (m_iv && !issue_ready)) return '0;
    for (int k = 1; k <= NR; k++) begin
      int i;
`ifdef LLC_ADMIT_RR_EN
      i = (m_last + k) % NR;
`else
      i = k - 1;
`endif
      if (req_valid[i] && !m_hit(req_set[i*SB +: SB])) return NR'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_check();
    chk("req_ready", req_ready, m_ready());
    chk("issue_valid", issue_valid, m_iv);
    chk("issue_req_id", issue_req_id, m_id);
    chk("issue_set", issue_set, m_iset);
    chk("issue_entry", issue_entry, m_ient);
    chk("occupancy", occupancy, m_occ());
    chk("table_full", table_full, m_occ() == TS);
    chk("drain_done", drain_done, m_st == 2);
  endtask

  task automatic model_step();
    logic [NR-1:0] r;
    int fe, g;
    r = m_ready();
    fe = 0;
    while (fe < TS && m_v[fe]) fe++;
    if (retire_valid && int'(retire_entry) < TS) m_v[retire_entry] = 1'b0;
    if (r != '0) begin
      g = 0;
      for (int i = 0; i < NR; i++) if (r[i]) g = i;
      m_v[fe] = 1'b1;
      m_s[fe] = req_set[g*SB +: SB];
      m_iv = 1'b1; m_id = g; m_iset = req_set[g*SB +: SB]; m_ient = fe; m_last = g;
    end else if (issue_ready) m_iv = 1'b0;
    if (m_st == 0) m_st = drain_req ? 1 : 0;
    else if (!drain_req) m_st = 0;
    else if (m_occ() == 0 && !m_iv) m_st = 2;
  endtask

  task automatic drive(input logic [NR-1:0] rv, input logic [SB-1:0] s0, s1, s2, s3,
                       input logic ir, rt, input logic [PW-1:0] re, input logic dr);
    req_valid = rv; req_set = {s3, s2, s1, s0}; issue_ready = ir;
    retire_valid = rt; retire_entry = re; drain_req = dr;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] rv; logic [SB-1:0] s0, s1; logic ir, rt; logic [PW-1:0] re; logic dr;
    logic [NR-1:0] e_rdy; logic e_iv; logic [PW-1:0] e_ent; logic [SB-1:0] e_set;
    logic [PW:0] e_occ; logic e_full, e_done;
  } vec_t;

  function automatic vec_t mk(logic [NR-1:0] rv, logic [SB-1:0] s0, s1, logic ir, rt, logic [PW-1:0] re,
                              logic dr, logic [NR-1:0] e_rdy, logic e_iv, logic [PW-1:0] e_ent,
                              logic [SB-1:0] e_set, logic [PW:0] e_occ, logic e_full, e_done);
    vec_t v;
    v.rv = rv; v.s0 = s0; v.s1 = s1; v.ir = ir; v.rt = rt; v.re = re; v.dr = dr;
    v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_ent = e_ent; v.e_set = e_set;
    v.e_occ = e_occ; v.e_full = e_full; v.e_done = e_done;
    return v;
  endfunction

  vec_t vt [26];
  logic [NR-1:0] ord [NR];
  logic [NR-1:0] mask;
  logic dr_lvl;

  initial begin
    vt[0]  = mk(4'b0001, 8'h12, 8'h00, 1, 0, 0, 0, 4'b0001, 0, 0, 8'h00, 0, 0, 0);
    vt[1]  = mk(4'b0011, 8'h12, 8'h34, 1, 0, 0, 0, 4'b0010, 1, 0, 8'h12, 1, 0, 0);
    vt[2]  = mk(4'b0001, 8'h12, 8'h00, 1, 1, 0, 0, 4'b0000, 1, 1, 8'h34, 2, 0, 0);
    vt[3]  = mk(4'b0001, 8'h12, 8'h00, 1, 0, 0, 0, 4'b0001, 0, 0, 8'h00, 1, 0, 0);
    vt[4]  = mk(4'b0001, 8'h56, 8'h00, 1, 0, 0, 0, 4'b0001, 1, 0, 8'h12, 2, 0, 0);
    vt[5]  = mk(4'b0001, 8'h78, 8'h00, 1, 0, 0, 0, 4'b0001, 1, 2, 8'h56, 3, 0, 0);
    vt[6]  = mk(4'b0001, 8'h9a, 8'h00, 1, 0, 0, 0, 4'b0001, 1, 3, 8'h78, 4, 0, 0);
    vt[7]  = mk(4'b0001, 8'hbc, 8'h00, 1, 0, 0, 0, 4'b0000, 1, 4, 8'h9a, 5, 1, 0);
    vt[8]  = mk(4'b0001, 8'hbc, 8'h00, 1, 1, 2, 0, 4'b0000, 0, 0, 8'h00, 5, 1, 0);
    vt[9]  = mk(4'b0001, 8'hbc, 8'h00, 1, 0, 0, 0, 4'b0001, 0, 0, 8'h00, 4, 0, 0);
    vt[10] = mk(4'b0000, 8'h00, 8'h00, 0, 1, 0, 0, 4'b0000, 1, 2, 8'hbc, 5, 1, 0);
    vt[11] = mk(4'b0010, 8'h00, 8'hde, 0, 0, 0, 0, 4'b0000, 1, 2, 8'hbc, 4, 0, 0);
    vt[12] = mk(4'b0010, 8'h00, 8'hde, 0, 0, 0, 0, 4'b0000, 1, 2, 8'hbc, 4, 0, 0);
    vt[13] = mk(4'b0010, 8'h00, 8'hde, 0, 0, 0, 0, 4'b0000, 1, 2, 8'hbc, 4, 0, 0);
    vt[14] = mk(4'b0010, 8'h00, 8'hde, 1, 0, 0, 0, 4'b0010, 1, 2, 8'hbc, 4, 0, 0);
    vt[15] = mk(4'b0000, 8'h00, 8'h00, 1, 0, 0, 0, 4'b0000, 1, 0, 8'hde, 5, 1, 0);
    vt[16] = mk(4'b0000, 8'h00, 8'h00, 1, 1, 0, 0, 4'b0000, 0, 0, 8'h00, 5, 1, 0);
    vt[17] = mk(4'b0000, 8'h00, 8'h00, 1, 1, 1, 0, 4'b0000, 0, 0, 8'h00, 4, 0, 0);
    vt[18] = mk(4'b0000, 8'h00, 8'h00, 1, 1, 2, 0, 4'b0000, 0, 0, 8'h00, 3, 0, 0);
    vt[19] = mk(4'b0001, 8'h11, 8'h00, 1, 0, 0, 1, 4'b0000, 0, 0, 8'h00, 2, 0, 0);
    vt[20] = mk(4'b0001, 8'h11, 8'h00, 1, 1, 3, 1, 4'b0000, 0, 0, 8'h00, 2, 0, 0);
    vt[21] = mk(4'b0001, 8'h11, 8'h00, 1, 1, 4, 1, 4'b0000, 0, 0, 8'h00, 1, 0, 0);
    vt[22] = mk(4'b0001, 8'h11, 8'h00, 1, 0, 0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1);
    vt[23] = mk(4'b0001, 8'h11, 8'h00, 1, 0, 0, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 1);
    vt[24] = mk(4'b0001, 8'h11, 8'h00, 1, 0, 0, 0, 4'b0001, 0, 0, 8'h00, 0, 0, 0);
    vt[25] = mk(4'b0000, 8'h00, 8'h00, 1, 0, 0, 0, 4'b0000, 1, 0, 8'h11, 1, 0, 0);
`ifdef LLC_ADMIT_RR_EN
    ord[0] = 4'b0010; ord[1] = 4'b0100; ord[2] = 4'b1000; ord[3] = 4'b0001;
`else
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100; ord[3] = 4'b1000;
`endif
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst issue_valid", issue_valid, 0);
    chk("rst issue_req_id", issue_req_id, 0);
    chk("rst issue_set", issue_set, 0);
    chk("rst issue_entry", issue_entry, 0);
    chk("rst drain_done", drain_done, 0);
    chk("rst table_full", table_full, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst req_ready", req_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 26; n++) begin
      drive(vt[n].rv, vt[n].s0, vt[n].s1, 8'h00, 8'h00, vt[n].ir, vt[n].rt, vt[n].re, vt[n].dr);
      chk($sformatf("v%0d req_ready", n), req_ready, vt[n].e_rdy);
      chk($sformatf("v%0d issue_valid", n), issue_valid, vt[n].e_iv);
      if (vt[n].e_iv) begin
        chk($sformatf("v%0d issue_entry", n), issue_entry, vt[n].e_ent);
        chk($sformatf("v%0d issue_set", n), issue_set, vt[n].e_set);
      end
      chk($sformatf("v%0d occupancy", n), occupancy, vt[n].e_occ);
      chk($sformatf("v%0d table_full", n), table_full, vt[n].e_full);
      chk($sformatf("v%0d drain_done", n), drain_done, vt[n].e_done);
      advance();
    end
    drive('0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
    advance();
    mask = 4'b1111;
    for (int n = 0; n < NR; n++) begin
      drive(mask, 8'ha0, 8'ha1, 8'ha2, 8'ha3, 1, 0, 0, 0);
      chk($sformatf("order%0d", n), req_ready, ord[n]);
      mask = mask & ~ord[n];
      advance();
    end
    for (int e = 0; e < NR; e++) begin
      drive('0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, PW'(e), 0);
      advance();
    end
    dr_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) dr_lvl = !dr_lvl;
      drive(NR'($urandom), SB'($urandom_range(0, 7)), SB'($urandom_range(0, 7)), SB'($urandom_range(0, 7)),
            SB'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            PW'($urandom_range(0, TS - 1)), dr_lvl);
      advance();
    end
    req_valid = '0; retire_valid = 1'b0; drain_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midrst issue_valid", issue_valid, 0);
    chk("midrst occupancy", occupancy, 0);
    chk("midrst table_full", table_full, 0);
    chk("midrst drain_done", drain_done, 0);
    chk("midrst issue_entry", issue_entry, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 300; n++) begin
      drive(NR'($urandom), SB'($urandom_range(0, 7)), SB'($urandom_range(0, 7)), SB'($urandom_range(0, 7)),
            SB'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            PW'($urandom_range(0, TS - 1)), 1'b0);
      advance();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
